// File: rtl/sev_seg_pkg.sv
// ============================================================================
// Module      : sev_seg_pkg
// Description : Glyph code type, named glyph constants and glyph decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sev_seg_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t     GLYPH_BLANK  = 5'h10;
  localparam glyph_t     GLYPH_DASH   = 5'h11;
  localparam glyph_t     GLYPH_EQUALS = 5'h12;
  localparam logic [6:0] SEG_BLANK    = 7'b1111111;

  // Active-low {a,b,c,d,e,f,g}; unassigned codes fall back to a dash.
  function automatic logic [6:0] glyph_to_seg(input glyph_t g);
    logic [6:0] s;
    case (g)
      5'h00:        s = 7'b0000001;
      5'h01:        s = 7'b1001111;
      5'h02:        s = 7'b0010010;
      5'h03:        s = 7'b0000110;
      5'h04:        s = 7'b1001100;
      5'h05:        s = 7'b0100100;
      5'h06:        s = 7'b0100000;
      5'h07:        s = 7'b0001111;
      5'h08:        s = 7'b0000000;
      5'h09:        s = 7'b0000100;
      5'h0A:        s = 7'b0001000;
      5'h0B:        s = 7'b1100000;
      5'h0C:        s = 7'b0110001;
      5'h0D:        s = 7'b1000010;
      5'h0E:        s = 7'b0110000;
      5'h0F:        s = 7'b0111000;
      GLYPH_BLANK:  s = SEG_BLANK;
      GLYPH_DASH:   s = 7'b1111110;
      GLYPH_EQUALS: s = 7'b1110110;
      default:      s = 7'b1111110;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sev_seg_scan_decoder.sv
// ============================================================================
// Module      : seg_decoder
// Description : Combinational glyph code to active-low segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_decoder (
  input  logic [4:0] glyph,
  output logic [6:0] seg
);
  import sev_seg_pkg::*;

  assign seg = glyph_to_seg(glyph_t'(glyph));

endmodule

`default_nettype wire

// File: rtl/sev_seg_scan.sv
// ============================================================================
// Module      : sev_seg_scan
// Description : Double-buffered, time-multiplexed N-digit seven-segment
//               driver. Define SEVSEG_BLINK_EN to enable per-digit blinking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sev_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV_W  = 16,
  parameter int BLINK_DIV_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] glyph_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);
  import sev_seg_pkg::*;

  localparam int              IDX_W    = $clog2(NUM_DIGITS);
  localparam int              GW       = 5 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_W-1:0] r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_tick;
  logic                  w_wrap;

  logic [GW-1:0]         r_sh_glyph;
  logic [GW-1:0]         r_act_glyph;
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [NUM_DIGITS-1:0] r_act_dp;
  logic [NUM_DIGITS-1:0] r_sh_blink;
  logic [NUM_DIGITS-1:0] r_act_blink;
  logic                  r_pending;

  logic [4:0]            w_sel_glyph;
  logic                  w_sel_dp;
  logic                  w_sel_blink;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [6:0]            w_dec_seg;
  logic                  w_blank;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  assign w_tick = &r_presc;
  // ">=" rather than "==" so a corrupted index still returns to 0.
  assign w_wrap = w_tick && (r_idx >= LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx >= LAST_IDX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Adoption happens on the wrap edge so digit 0 of the new frame is the
  // first digit to show the new content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_glyph  <= {NUM_DIGITS{GLYPH_BLANK}};
      r_act_glyph <= {NUM_DIGITS{GLYPH_BLANK}};
      r_sh_dp     <= '0;
      r_act_dp    <= '0;
      r_sh_blink  <= '0;
      r_act_blink <= '0;
      r_pending   <= 1'b0;
    end else if (load && w_wrap) begin
      r_sh_glyph  <= glyph_in;
      r_sh_dp     <= dp_in;
      r_sh_blink  <= blink_mask;
      r_act_glyph <= glyph_in;
      r_act_dp    <= dp_in;
      r_act_blink <= blink_mask;
      r_pending   <= 1'b0;
    end else if (load) begin
      r_sh_glyph  <= glyph_in;
      r_sh_dp     <= dp_in;
      r_sh_blink  <= blink_mask;
      r_pending   <= 1'b1;
    end else if (w_wrap && r_pending) begin
      r_act_glyph <= r_sh_glyph;
      r_act_dp    <= r_sh_dp;
      r_act_blink <= r_sh_blink;
      r_pending   <= 1'b0;
    end
  end

  always_comb begin
    w_sel_glyph = GLYPH_BLANK;
    w_sel_dp    = 1'b0;
    w_sel_blink = 1'b0;
    w_an_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_sel_glyph  = r_act_glyph[5*k +: 5];
        w_sel_dp     = r_act_dp[k];
        w_sel_blink  = r_act_blink[k];
        w_an_next[k] = 1'b0;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .glyph (w_sel_glyph),
    .seg   (w_dec_seg)
  );

`ifdef SEVSEG_BLINK_EN
  logic [BLINK_DIV_W-1:0] r_frame_cnt;
  logic                   r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
      if (&r_frame_cnt) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign w_blank = r_phase & w_sel_blink;
`else
  logic                   w_unused_blink;
  logic [BLINK_DIV_W-1:0] w_unused_blink_div;

  assign w_unused_blink     = w_sel_blink;
  assign w_unused_blink_div = '0;
  assign w_blank            = 1'b0;
`endif

  // Blanked digits keep their enable low so scan timing is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_blank ? SEG_BLANK : w_dec_seg;
      r_dp         <= w_blank ? 1'b1 : ~w_sel_dp;
      r_an         <= w_an_next;
      r_frame_done <= w_wrap;
    end
  end

  assign seg            = r_seg;
  assign dp             = r_dp;
  assign an             = r_an;
  assign frame_done     = r_frame_done;
  assign update_pending = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_sev_seg_scan.sv
// ============================================================================
// Module      : tb_sev_seg_scan
// Description : Scoreboard bench for sev_seg_scan (4 digits, 4-clock digits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sev_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] glyph_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        update_pending;

  always #5 clk = ~clk;

  sev_seg_scan #(
    .NUM_DIGITS  (4),
    .SCAN_DIV_W  (2),
    .BLINK_DIV_W (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .glyph_in       (glyph_in),
    .dp_in          (dp_in),
    .blink_mask     (blink_mask),
    .seg            (seg),
    .dp             (dp),
    .an             (an),
    .frame_done     (frame_done),
    .update_pending (update_pending)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [6:0] fs [9][4];
  logic [3:0] fdp [9];
  logic [3:0] fblank [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  // Monitor: every change of the digit enables is one presented digit.
  logic [3:0] prev_an = 4'hF;
  int         hold = 0;
  bit         first_chg = 1'b1;
  int         last_fd = 0;
  int         n_pop = 0;
  exp_t       e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (an !== prev_an) begin
        if (!first_chg) check("digit_hold", hold, 4);
        first_chg = 1'b0;
        hold      = 1;
        prev_an   = an;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got an=%b, expected no further digit", an);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("an[%0d]", n_pop), an, e.an);
          check($sformatf("seg[%0d]", n_pop), seg, e.seg);
          check($sformatf("dp[%0d]", n_pop), dp, e.dp);
          n_pop++;
        end
      end else begin
        hold++;
      end
      if (frame_done === 1'b1) begin
        check("frame_done_period", cyc - last_fd, 16);
        last_fd = cyc;
      end
    end
  end

  task automatic load_at(input int edge_n, input logic [19:0] g, input logic [3:0] d,
                         input logic [3:0] m);
    int guard = 0;
    while (cyc != edge_n - 1) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        $display("FAIL load_wait: got cycle %0d, expected %0d", cyc, edge_n - 1);
        $fatal(1);
      end
    end
    glyph_in   = g;
    dp_in      = d;
    blink_mask = m;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        $display("FAIL cycle_wait: got cycle %0d, expected %0d", cyc, n);
        $fatal(1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] one;
    exp_t       x;
    one = 4'b0001;

    // Frame expectations, digits 0..3 in scan order.
    for (int f = 0; f < 9; f++) begin
      fdp[f]    = 4'b0000;
      fblank[f] = 4'b0000;
      for (int d = 0; d < 4; d++) fs[f][d] = 7'b1111111;
    end
    fs[2][0] = 7'b0100100; fs[2][1] = 7'b1111110; fs[2][2] = 7'b0111000; fs[2][3] = 7'b1110110;
    for (int f = 3; f < 5; f++) begin
      fs[f][0] = 7'b0000110; fs[f][1] = 7'b0000000; fs[f][2] = 7'b0110001; fs[f][3] = 7'b1111110;
      fdp[f]   = 4'b0010;
    end
    for (int f = 5; f < 9; f++) begin
      fs[f][0] = 7'b0100000; fs[f][1] = 7'b0001111; fs[f][2] = 7'b0000100; fs[f][3] = 7'b0110000;
    end
`ifdef SEVSEG_BLINK_EN
    fblank[6] = 4'b0001;
    fblank[7] = 4'b0001;
`endif
    for (int f = 0; f < 9; f++) begin
      for (int d = 0; d < 4; d++) begin
        x.an  = ~(one << d);
        x.seg = fblank[f][d] ? 7'b1111111 : fs[f][d];
        x.dp  = fblank[f][d] ? 1'b1 : ~fdp[f][d];
        sb_q.push_back(x);
      end
    end

    repeat (3) @(negedge clk);
    check("reset_seg", seg, 7'b1111111);
    check("reset_dp", dp, 1'b1);
    check("reset_an", an, 4'b1111);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_pending", update_pending, 1'b0);

    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Mid-frame load while the index is 2.
    load_at(26, {5'h12, 5'h0F, 5'h11, 5'h05}, 4'b0000, 4'b0000);
    check("pending_after_load", update_pending, 1'b1);
    wait_cyc(31);
    check("pending_before_boundary", update_pending, 1'b1);
    wait_cyc(32);
    check("pending_after_adopt", update_pending, 1'b0);

    // Load coinciding with the wrap edge; includes undefined code 0x1A.
    load_at(48, {5'h1A, 5'h0C, 5'h08, 5'h03}, 4'b0010, 4'b0000);
    check("pending_load_on_wrap", update_pending, 1'b0);

    // Two loads before the boundary; only the second may ever appear.
    load_at(66, {5'h01, 5'h02, 5'h03, 5'h04}, 4'b1111, 4'b1111);
    check("pending_first_load", update_pending, 1'b1);
    load_at(70, {5'h0E, 5'h09, 5'h07, 5'h06}, 4'b0000, 4'b0001);
    check("pending_second_load", update_pending, 1'b1);
    wait_cyc(80);
    check("pending_after_double", update_pending, 1'b0);

    wait_cyc(142);
    mon_en = 1'b0;
    check("scoreboard_drained", sb_q.size(), 0);

    // Asynchronous reset with an update pending.
    load_at(147, {5'h08, 5'h08, 5'h08, 5'h08}, 4'b1111, 4'b0000);
    check("pending_before_reset", update_pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_seg", seg, 7'b1111111);
    check("async_reset_dp", dp, 1'b1);
    check("async_reset_an", an, 4'b1111);
    check("async_reset_frame_done", frame_done, 1'b0);
    check("async_reset_pending", update_pending, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_an", an, 4'b1110);
    check("post_reset_seg", seg, 7'b1111111);
    repeat (16) @(negedge clk);
    check("discarded_load_an", an, 4'b1110);
    check("discarded_load_seg", seg, 7'b1111111);
    check("discarded_load_dp", dp, 1'b1);
    check("discarded_load_pending", update_pending, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sev_seg_scan.md
# sev_seg_scan

Parametrised, time-multiplexed seven-segment display driver for N common-anode digits. It replaces the fixed 4-digit hex driver for the board display, for example the memory, checksum and counter views. Clients load a full frame of glyph codes with a one-cycle strobe. The block double-buffers the frame, adopts it only at a frame boundary so the display never tears, scans the digits with a programmable refresh divider, and can optionally blink selected digits.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (≥2).
- SCAN_DIV_W, 16: prescaler width; the digit advances every 2^SCAN_DIV_W clocks.
- BLINK_DIV_W, 6: blink phase toggles every 2^BLINK_DIV_W completed frames.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load  in  1  single-cycle strobe; captures glyph_in, dp_in and blink_mask into the shadow frame.
- glyph_in  in  5*NUM_DIGITS  glyph codes; digit k occupies [5k+4:5k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- blink_mask  in  NUM_DIGITS  digits that blink, active-high.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.
- update_pending  out  1  high while the shadow frame holds data the display has not yet adopted.

## Operation
- Prescaler: counts 0 to 2^SCAN_DIV_W−1 and wraps. `tick` is asserted when the prescaler is all-ones.
- Digit index: advances by 1 on each tick. After NUM_DIGITS−1 it wraps to 0, and the same cycle asserts frame_done.
- Shadow and active frames:
  - load copies the inputs into the shadow frame and sets update_pending.
  - On a frame_done cycle with update_pending set, the shadow frame is copied to the active frame and update_pending clears.
  - load on the same edge as frame_done: the new inputs go directly into the active frame, and update_pending ends low.
  - A second load before adoption overwrites the shadow frame. Only the last load is shown.
- Glyph decode (active-low {a..g}):
  - Hex digits: 0x00=0000001, 0x01=1001111, 0x02=0010010, 0x03=0000110, 0x04=1001100, 0x05=0100100, 0x06=0100000, 0x07=0001111, 0x08=0000000, 0x09=0000100, 0x0A=0001000, 0x0B=1100000, 0x0C=0110001, 0x0D=1000010, 0x0E=0110000, 0x0F=0111000.
  - Symbols: 0x10 blank=1111111, 0x11 dash=1111110, 0x12 equals=1110110.
  - Codes 0x13–0x1F decode as dash.
- dp output is the inverse of the active dp bit of the selected digit.
- Blink: see Configuration. A blanked digit drives seg=1111111, dp=1, and keeps its an bit low so the scan timing is unchanged.

## Timing
- seg, dp, an and frame_done are registered.
- An index change appears on an, seg and dp one clock later.
- One full frame lasts NUM_DIGITS·2^SCAN_DIV_W clocks.
- Reset values:
  - prescaler 0, index 0, blink phase 0;
  - active and shadow glyphs all 0x10 (blank); dp and blink_mask bits 0;
  - seg=1111111, dp=1, an all ones, frame_done=0, update_pending=0.
- First edge after reset release: an = ~1 (digit 0 enabled), seg blank.
- Reset asserted mid-frame: all state returns to the reset values immediately; a pending update is discarded.
- The index is never out of range. Any out-of-range value recovers to 0 on the next tick.

## Configuration
- SEVSEG_BLINK_EN defined:
  - A frame counter of BLINK_DIV_W bits toggles the blink phase when it wraps.
  - While the phase is 1, every active digit whose blink_mask bit is set is blanked.
- Undefined:
  - No blink counter or phase state exists.
  - The blink_mask port remains, is captured, and has no effect on the outputs.

## Structure
- Package sev_seg_pkg holds:
  - the glyph code typedef `glyph_t` (5-bit);
  - the named constants GLYPH_BLANK, GLYPH_DASH and GLYPH_EQUALS;
  - a decode function glyph_to_seg.
- Sub-module seg_decoder: combinational glyph_t to 7-bit seg, used once on the selected digit.
- The top module owns the prescaler, index, shadow/active buffers, blink logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV_W=2 and BLINK_DIV_W=1.
- Reset and scan: release reset with no load.
  - an cycles 1110, 1101, 1011, 0111, each held 4 clocks, with seg=1111111 throughout.
  - frame_done pulses every 16 clocks.
- Load mid-frame: load glyphs {3,2,1,0}=0x12,0x0F,0x11,0x05 while the index is 2.
  - update_pending goes high; seg stays blank until the next frame_done.
  - Next frame shows 0100100, 1111110, 0111000, 1110110 on digits 0–3.
- Load on the frame_done edge: new glyphs are shown in the frame that starts, and update_pending stays 0.
- Double load before the boundary: only the second frame is ever shown.
- Decimal point and undefined codes: dp_in=0010 gives dp=0 only while an=1101; glyph 0x1A decodes as 1111110.
- Blink with SEVSEG_BLINK_EN, blink_mask=0001:
  - digit 0 is blank on alternate frame pairs (2 frames shown, 2 frames blank), and an still pulses low.
  - Without the macro, digit 0 is always shown.
- Reset during a pending load: update_pending=0 and all outputs return to their reset values asynchronously.
